// File: rtl/hazard_stall_unit_pkg.sv
// Shared hazard-detection types and helpers for the pipeline interlock and forwarding logic.
package pipeline_hazard_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an instruction reads srcAddr and it is the register being produced at dstAddr.
    function automatic logic src_match(input logic [4:0] srcAddr,
                                       input logic       srcUse,
                                       input logic [4:0] dstAddr);
        return srcUse & (srcAddr == dstAddr);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard-observation bus and interlock controls of the stall unit.
interface hazard_stall_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             RsAddr_id;
    logic [4:0]             RtAddr_id;
    logic                   RsUse_id;
    logic                   RtUse_id;
    logic                   MduUse_id;
    logic                   MemRead_ex;
    logic                   RegWrite_ex;
    logic [4:0]             RegWriteAddr_ex;
    logic                   MduStart_ex;
    logic                   PC_stall;
    logic                   IFID_stall;
    logic                   IDEX_flush;
    logic                   mdu_busy;
    logic                   mdu_overlap_err;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output RsAddr_id, RtAddr_id, RsUse_id, RtUse_id, MduUse_id,
               MemRead_ex, RegWrite_ex, RegWriteAddr_ex, MduStart_ex,
        input  PC_stall, IFID_stall, IDEX_flush, mdu_busy, mdu_overlap_err, stall_cycles
    );

    modport slave (
        input  RsAddr_id, RtAddr_id, RsUse_id, RtUse_id, MduUse_id,
               MemRead_ex, RegWrite_ex, RegWriteAddr_ex, MduStart_ex,
        output PC_stall, IFID_stall, IDEX_flush, mdu_busy, mdu_overlap_err, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit_mdu_busy_counter.sv
// Tracks an in-flight mult/div: busy FSM, latency down-counter and sticky overlap flag.
module mdu_busy_counter
    import pipeline_hazard_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic mduStart,
    output logic mduBusy,
    output logic overlapErr
);
    localparam int               CNT_W    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(MDU_LAT - 1);
    localparam bit               CAN_BUSY = (MDU_LAT > 1);

    mdu_state_t       state_r, stateNext_s;
    logic [CNT_W-1:0] cnt_r, cntNext_s;
    logic             err_r, errNext_s;

    // State, counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            cnt_r   <= cntNext_s;
            err_r   <= errNext_s;
        end
    end

    // Next-state: a start while busy is an illegal issue; restart the latency and flag it.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        errNext_s   = err_r;
        case (state_r)
            IDLE: begin
                if (mduStart && CAN_BUSY) begin
                    stateNext_s = BUSY;
                    cntNext_s   = RELOAD;
                end else begin
                    stateNext_s = IDLE;
                    cntNext_s   = {CNT_W{1'b0}};
                end
            end
            BUSY: begin
                if (mduStart) begin
                    errNext_s   = 1'b1;
                    cntNext_s   = RELOAD;
                end else if (cnt_r == CNT_W'(1)) begin
                    stateNext_s = IDLE;
                    cntNext_s   = {CNT_W{1'b0}};
                end else begin
                    cntNext_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                stateNext_s = IDLE;
                cntNext_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign mduBusy    = (state_r == BUSY);
    assign overlapErr = err_r;
endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and multi-cycle MDU interlock: stalls PC/IF-ID, bubbles ID/EX, counts stall cycles.
module hazard_stall_unit
    import pipeline_hazard_pkg::*;
#(
    parameter int MDU_LAT     = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_unit_if.slave hz
);
    logic                   busyRaw_s;
    logic                   mduBusy_s;
    logic                   loadHz_s;
    logic                   mduHz_s;
    logic                   stall_s;
    logic [STALL_CNT_W-1:0] stallCycles_r;

    mdu_busy_counter #(
        .MDU_LAT (MDU_LAT)
    ) u_mduBusyCounter (
        .clk        (clk),
        .rst        (rst),
        .mduStart   (hz.MduStart_ex),
        .mduBusy    (busyRaw_s),
        .overlapErr (hz.mdu_overlap_err)
    );

    // Hazard conditions; everything is held quiet while reset is asserted.
    always_comb begin
        mduBusy_s = 1'b0;
        loadHz_s  = 1'b0;
        mduHz_s   = 1'b0;
        stall_s   = 1'b0;
        if (rst) begin
            mduBusy_s = 1'b0;
            stall_s   = 1'b0;
        end else begin
            mduBusy_s = busyRaw_s;
            loadHz_s  = hz.MemRead_ex & hz.RegWrite_ex & (hz.RegWriteAddr_ex != REG_ZERO) &
                        (src_match(hz.RsAddr_id, hz.RsUse_id, hz.RegWriteAddr_ex) |
                         src_match(hz.RtAddr_id, hz.RtUse_id, hz.RegWriteAddr_ex));
            mduHz_s   = hz.MduUse_id & (hz.MduStart_ex | busyRaw_s);
            stall_s   = loadHz_s | mduHz_s;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stallCycles_r != {STALL_CNT_W{1'b1}})) begin
            stallCycles_r <= stallCycles_r + STALL_CNT_W'(1);
        end else begin
            stallCycles_r <= stallCycles_r;
        end
    end

    assign hz.PC_stall     = stall_s;
    assign hz.IFID_stall   = stall_s;
    assign hz.IDEX_flush   = stall_s;
    assign hz.mdu_busy     = mduBusy_s;
    assign hz.stall_cycles = stallCycles_r;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MDU_LAT=4) plus a narrow-counter instance.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst;
    logic rstSat;
    int   checks   = 0;
    int   failures = 0;

    hazard_stall_unit_if #(.STALL_CNT_W(16)) hz ();
    hazard_stall_unit_if #(.STALL_CNT_W(4))  hzSat ();

    hazard_stall_unit #(.MDU_LAT(4), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    hazard_stall_unit #(.MDU_LAT(4), .STALL_CNT_W(4)) dutSat (
        .clk (clk),
        .rst (rstSat),
        .hz  (hzSat)
    );

    assign hzSat.RsAddr_id       = hz.RsAddr_id;
    assign hzSat.RtAddr_id       = hz.RtAddr_id;
    assign hzSat.RsUse_id        = hz.RsUse_id;
    assign hzSat.RtUse_id        = hz.RtUse_id;
    assign hzSat.MduUse_id       = hz.MduUse_id;
    assign hzSat.MemRead_ex      = hz.MemRead_ex;
    assign hzSat.RegWrite_ex     = hz.RegWrite_ex;
    assign hzSat.RegWriteAddr_ex = hz.RegWriteAddr_ex;
    assign hzSat.MduStart_ex     = hz.MduStart_ex;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStall(input string tag, input logic exp);
        check({tag, "_pc"},   {31'd0, hz.PC_stall},   {31'd0, exp});
        check({tag, "_ifid"}, {31'd0, hz.IFID_stall}, {31'd0, exp});
        check({tag, "_idex"}, {31'd0, hz.IDEX_flush}, {31'd0, exp});
    endtask

    task automatic clearInputs();
        hz.RsAddr_id       = 5'd0;
        hz.RtAddr_id       = 5'd0;
        hz.RsUse_id        = 1'b0;
        hz.RtUse_id        = 1'b0;
        hz.MduUse_id       = 1'b0;
        hz.MemRead_ex      = 1'b0;
        hz.RegWrite_ex     = 1'b0;
        hz.RegWriteAddr_ex = 5'd0;
        hz.MduStart_ex     = 1'b0;
    endtask

    task automatic setLoadUse();
        hz.MemRead_ex      = 1'b1;
        hz.RegWrite_ex     = 1'b1;
        hz.RegWriteAddr_ex = 5'd5;
        hz.RsAddr_id       = 5'd5;
        hz.RsUse_id        = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with hazardous inputs present: outputs must be forced low.
        rst = 1'b1;
        rstSat = 1'b1;
        clearInputs();
        setLoadUse();
        hz.MduStart_ex = 1'b1;
        hz.MduUse_id   = 1'b1;
        #1;
        checkStall("rst_forced", 1'b0);
        check("rst_busy", {31'd0, hz.mdu_busy}, 32'd0);
        tick();
        tick();
        check("rst_cnt", {16'd0, hz.stall_cycles}, 32'd0);
        check("rst_err", {31'd0, hz.mdu_overlap_err}, 32'd0);
        check("rst_busy2", {31'd0, hz.mdu_busy}, 32'd0);
        clearInputs();
        rst = 1'b0;
        rstSat = 1'b0;
        #1;
        checkStall("idle", 1'b0);

        // 1: load-use on rs, one stall then bubble.
        setLoadUse();
        #1;
        checkStall("lu_rs", 1'b1);
        tick();
        hz.MemRead_ex  = 1'b0;
        hz.RegWrite_ex = 1'b0;
        #1;
        checkStall("lu_bubble", 1'b0);
        check("lu_cnt", {16'd0, hz.stall_cycles}, 32'd1);

        // 2: $0 destination and unused rs never stall; rt match does.
        setLoadUse();
        hz.RegWriteAddr_ex = 5'd0;
        hz.RsAddr_id       = 5'd0;
        #1;
        checkStall("lu_zero", 1'b0);
        tick();
        setLoadUse();
        hz.RsUse_id = 1'b0;
        #1;
        checkStall("lu_nouse", 1'b0);
        tick();
        hz.RtAddr_id = 5'd5;
        hz.RtUse_id  = 1'b1;
        #1;
        checkStall("lu_rt", 1'b1);
        tick();
        clearInputs();
        #1;
        check("lu_cnt2", {16'd0, hz.stall_cycles}, 32'd2);

        // 3: MDU start at cycle 0, mfhi in ID; stalls 0..3, busy 1..3.
        hz.MduStart_ex = 1'b1;
        hz.MduUse_id   = 1'b1;
        #1;
        checkStall("mdu_c0", 1'b1);
        check("mdu_c0_busy", {31'd0, hz.mdu_busy}, 32'd0);
        tick();
        hz.MduStart_ex = 1'b0;
        #1;
        checkStall("mdu_c1", 1'b1);
        check("mdu_c1_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        check("mdu_c2_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        checkStall("mdu_c3", 1'b1);
        check("mdu_c3_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        checkStall("mdu_c4", 1'b0);
        check("mdu_c4_busy", {31'd0, hz.mdu_busy}, 32'd0);
        check("mdu_err", {31'd0, hz.mdu_overlap_err}, 32'd0);
        check("mdu_cnt", {16'd0, hz.stall_cycles}, 32'd6);
        hz.MduUse_id = 1'b0;
        tick();

        // 4: load-use and MDU hazard together count once.
        setLoadUse();
        hz.MduStart_ex = 1'b1;
        hz.MduUse_id   = 1'b1;
        #1;
        checkStall("both", 1'b1);
        tick();
        check("both_cnt", {16'd0, hz.stall_cycles}, 32'd7);

        // 5: the start above was cycle 0; a second start at cycle 2 restarts the latency.
        clearInputs();
        #1;
        check("ov_c1_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        hz.MduStart_ex = 1'b1;
        #1;
        check("ov_c2_err", {31'd0, hz.mdu_overlap_err}, 32'd0);
        tick();
        hz.MduStart_ex = 1'b0;
        #1;
        check("ov_c3_err", {31'd0, hz.mdu_overlap_err}, 32'd1);
        check("ov_c3_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        tick();
        check("ov_c5_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        check("ov_c6_busy", {31'd0, hz.mdu_busy}, 32'd0);
        check("ov_c6_err", {31'd0, hz.mdu_overlap_err}, 32'd1);
        check("ov_cnt", {16'd0, hz.stall_cycles}, 32'd7);

        // Saturation: 20 more stalls; the 4-bit instance must hold at all-ones.
        setLoadUse();
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_main", {16'd0, hz.stall_cycles}, 32'd27);
        check("sat_narrow", {28'd0, hzSat.stall_cycles}, 32'd15);
        clearInputs();

        // 6: reset mid-BUSY with an active stall and a set error flag.
        hz.MduStart_ex = 1'b1;
        hz.MduUse_id   = 1'b1;
        tick();
        #1;
        checkStall("r6_c1", 1'b1);
        check("r6_c1_busy", {31'd0, hz.mdu_busy}, 32'd1);
        tick();
        hz.MduStart_ex = 1'b0;
        #1;
        check("r6_c2_err", {31'd0, hz.mdu_overlap_err}, 32'd1);
        rst = 1'b1;
        #1;
        checkStall("r6_inrst", 1'b0);
        check("r6_inrst_busy", {31'd0, hz.mdu_busy}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkStall("r6_after", 1'b0);
        check("r6_after_busy", {31'd0, hz.mdu_busy}, 32'd0);
        check("r6_after_cnt", {16'd0, hz.stall_cycles}, 32'd0);
        check("r6_after_err", {31'd0, hz.mdu_overlap_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
